// File: rtl/des_round_sequencer.sv
// des_round_sequencer
//   Control FSM for an iterative DES core. It walks one 64-bit block through
//   the shared round datapath: a single load cycle, ROUNDS round enables with
//   per-round C/D rotation control, then a result held under a valid/ready
//   handshake. Only control is produced here; data and key registers live in
//   the datapath.
//
//   Parameters
//     ROUNDS          rounds per block, 1..16 (values below 16 are for debug)
//     SHIFT_SCHEDULE  bit k set -> encrypt round k rotates C/D by 1, else by 2
//
//   Ports
//     i_clk            rising-edge clock
//     i_reset          synchronous active-high reset
//     i_start_valid    block + key present on datapath inputs, start request
//     o_start_ready    a start can be accepted (IDLE only)
//     i_decrypt        mode, sampled only on the start handshake (1 = decrypt)
//     o_data_load      datapath loads IP(block) into L/R
//     o_key_load       datapath loads PC-1(key) into C/D
//     o_round_en       datapath registers one round result + rotated C/D
//     o_round_idx      current round 0..ROUNDS-1 (0 outside rounds)
//     o_key_shift_amt  C/D rotation for this round: 0, 1 or 2
//     o_key_shift_dir  0 = rotate left (encrypt), 1 = rotate right (decrypt)
//     o_last_round     final round, skips the L/R swap
//     o_out_valid      FP(R16L16) on the datapath output is valid
//     i_out_ready      consumer accepts the result
//     o_busy           sequencer is not idle
//
//   All outputs are registers computed from the next state, so they are Moore
//   functions of state/counter/mode with no input-to-output combinational path.
module des_round_sequencer #(
  parameter int          ROUNDS         = 16,
  parameter logic [15:0] SHIFT_SCHEDULE = 16'h8103
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic       i_decrypt,
  output logic       o_data_load,
  output logic       o_key_load,
  output logic       o_round_en,
  output logic [3:0] o_round_idx,
  output logic [1:0] o_key_shift_amt,
  output logic       o_key_shift_dir,
  output logic       o_last_round,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  // Rotation amount for round k. Decryption undoes the encrypt rotations in
  // reverse order: its first round uses the untouched PC-1 key (amount 0),
  // and round k undoes encrypt round ROUNDS-k. The 4-bit subtraction wraps
  // 16 to 0, which is exact for ROUNDS=16 and k in 1..15.
  function automatic logic [1:0] shift_amt(input logic [3:0] k, input logic dec);
    logic [3:0] w_ridx;
    logic [1:0] w_amt;
    w_ridx = 4'(ROUNDS) - k;
    if (!dec) begin
      w_amt = SHIFT_SCHEDULE[k] ? 2'd1 : 2'd2;
    end else if (k == 4'd0) begin
      w_amt = 2'd0;
    end else begin
      w_amt = SHIFT_SCHEDULE[w_ridx] ? 2'd1 : 2'd2;
    end
    return w_amt;
  endfunction

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_mode;

  state_t     w_state_nx;
  logic [3:0] w_cnt_nx;
  logic       w_mode_nx;
  logic       w_in_round_nx;

  // Next-state, counter and mode-latch logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_mode_nx  = r_mode;
    case (r_state)
      S_IDLE: begin
        if (i_start_valid) begin
          w_state_nx = S_LOAD;
          w_mode_nx  = i_decrypt;
          w_cnt_nx   = 4'd0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nx = S_ROUND;
        w_cnt_nx   = 4'd0;
      end
      S_ROUND: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nx = S_DONE;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 4'd0;
        w_mode_nx  = 1'b0;
      end
    endcase
    w_in_round_nx = (w_state_nx == S_ROUND);
  end

  // State registers and registered Moore outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= 4'd0;
      r_mode          <= 1'b0;
      o_start_ready   <= 1'b1;
      o_data_load     <= 1'b0;
      o_key_load      <= 1'b0;
      o_round_en      <= 1'b0;
      o_round_idx     <= 4'd0;
      o_key_shift_amt <= 2'd0;
      o_key_shift_dir <= 1'b0;
      o_last_round    <= 1'b0;
      o_out_valid     <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_cnt           <= w_cnt_nx;
      r_mode          <= w_mode_nx;
      o_start_ready   <= (w_state_nx == S_IDLE);
      o_data_load     <= (w_state_nx == S_LOAD);
      o_key_load      <= (w_state_nx == S_LOAD);
      o_round_en      <= w_in_round_nx;
      o_round_idx     <= w_in_round_nx ? w_cnt_nx : 4'd0;
      o_key_shift_amt <= w_in_round_nx ? shift_amt(w_cnt_nx, w_mode_nx) : 2'd0;
      o_key_shift_dir <= w_in_round_nx ? w_mode_nx : 1'b0;
      o_last_round    <= w_in_round_nx && (w_cnt_nx == LAST_IDX);
      o_out_valid     <= (w_state_nx == S_DONE);
      o_busy          <= (w_state_nx != S_IDLE);
    end
  end

endmodule
